// File: rtl/imem_loader_if.sv
// Stream-in and instruction-memory write bundle for the boot loader.
// The loader takes the slave view. A source or bench takes the master view.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic [31:0]           in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: streams words into instruction memory and holds the
// core in reset until the end-marker word has been written.
module imem_loader #(
   parameter int          ADDR_WIDTH    = 8,
   parameter logic [31:0] END_MARKER    = 32'hFFFF_FFFF,
   parameter int          RELEASE_DELAY = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   imem_loader_if.slave        bus,
   output logic                cpu_reset,
   output logic                load_done,
   output logic                error,
   output logic [ADDR_WIDTH:0] word_count
);
   typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, ERROR} state_t;

   localparam int                    DW         = $clog2(RELEASE_DELAY + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
   localparam logic [DW-1:0]         DELAY_LAST = DW'(RELEASE_DELAY - 1);

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DW-1:0]         delay_reg;
   logic                  imem_we_reg;
   logic [ADDR_WIDTH-1:0] imem_addr_reg;
   logic [31:0]           imem_wdata_reg;
   logic                  cpu_reset_reg;
   logic                  load_done_reg;
   logic                  error_reg;
   logic [ADDR_WIDTH:0]   word_count_reg;

   // Ready is a pure decode of the state register, so there is no path from in_valid.
   assign bus.in_ready   = (state_reg == LOAD);
   assign bus.imem_we    = imem_we_reg;
   assign bus.imem_addr  = imem_addr_reg;
   assign bus.imem_wdata = imem_wdata_reg;
   assign cpu_reset      = cpu_reset_reg;
   assign load_done      = load_done_reg;
   assign error          = error_reg;
   assign word_count     = word_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         delay_reg      <= '0;
         imem_we_reg    <= 1'b0;
         imem_addr_reg  <= '0;
         imem_wdata_reg <= '0;
         cpu_reset_reg  <= 1'b1;
         load_done_reg  <= 1'b0;
         error_reg      <= 1'b0;
         word_count_reg <= '0;
      end else begin
         imem_we_reg <= 1'b0;
         case (state_reg)
            IDLE, RUN, ERROR: begin
               if (start) begin
                  state_reg      <= LOAD;
                  addr_reg       <= '0;
                  word_count_reg <= '0;
                  error_reg      <= 1'b0;
                  load_done_reg  <= 1'b0;
                  cpu_reset_reg  <= 1'b1;
               end
            end
            LOAD: begin
               if (bus.in_valid) begin
                  imem_we_reg    <= 1'b1;
                  imem_addr_reg  <= addr_reg;
                  imem_wdata_reg <= bus.in_data;
                  word_count_reg <= word_count_reg + 1'b1;
                  // The marker check comes before the full check, so a marker in the last slot loads cleanly.
                  if (bus.in_data == END_MARKER) begin
                     state_reg <= RELEASE;
                     delay_reg <= '0;
                  end else if (addr_reg == LAST_ADDR) begin
                     state_reg <= ERROR;
                     error_reg <= 1'b1;
                  end else begin
                     addr_reg <= addr_reg + 1'b1;
                  end
               end
            end
            RELEASE: begin
               if (delay_reg == DELAY_LAST) begin
                  state_reg     <= RUN;
                  cpu_reset_reg <= 1'b0;
                  load_done_reg <= 1'b1;
               end else begin
                  delay_reg <= delay_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a wide instance (8-bit address) and a tiny one (2-bit address).
// Expected writes are queued when words are driven and popped when the write appears.
module tb_imem_loader;
   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] data;
      int          exp_count;
   } vec_t;

   localparam int O_READY = 0, O_WE = 1, O_CPURST = 2, O_DONE = 3,
                  O_ERR = 4, O_COUNT = 5, O_ADDR = 6, O_WDATA = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, start_a, reset_b, start_b;
   logic       cpu_reset_a, load_done_a, error_a;
   logic       cpu_reset_b, load_done_b, error_b;
   logic [8:0] word_count_a;
   logic [2:0] word_count_b;

   imem_loader_if #(.ADDR_WIDTH(8)) bus_a ();
   imem_loader_if #(.ADDR_WIDTH(2)) bus_b ();

   imem_loader #(.ADDR_WIDTH(8)) dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .bus(bus_a),
      .cpu_reset(cpu_reset_a), .load_done(load_done_a), .error(error_a),
      .word_count(word_count_a)
   );

   imem_loader #(.ADDR_WIDTH(2)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .bus(bus_b),
      .cpu_reset(cpu_reset_b), .load_done(load_done_b), .error(error_b),
      .word_count(word_count_b)
   );

   int   checks = 0;
   int   errors = 0;
   wr_t  q_a[$];
   wr_t  q_b[$];
   vec_t prog[5];

   function automatic logic [31:0] obs(input bit sel, input int which);
      logic [31:0] v;
      v = '0;
      case (which)
         O_READY:  v = sel ? 32'(bus_b.in_ready)   : 32'(bus_a.in_ready);
         O_WE:     v = sel ? 32'(bus_b.imem_we)    : 32'(bus_a.imem_we);
         O_CPURST: v = sel ? 32'(cpu_reset_b)      : 32'(cpu_reset_a);
         O_DONE:   v = sel ? 32'(load_done_b)      : 32'(load_done_a);
         O_ERR:    v = sel ? 32'(error_b)          : 32'(error_a);
         O_COUNT:  v = sel ? 32'(word_count_b)     : 32'(word_count_a);
         O_ADDR:   v = sel ? 32'(bus_b.imem_addr)  : 32'(bus_a.imem_addr);
         default:  v = sel ? bus_b.imem_wdata      : bus_a.imem_wdata;
      endcase
      return v;
   endfunction

   task automatic check(input bit sel, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s_%s actual=%h required=%h t=%0t", sel ? "b" : "a", name, act, exp, $time);
      end
   endtask

   task automatic monitor(input bit sel);
      wr_t w;
      if (obs(sel, O_WE) === 32'd1) begin
         if ((sel ? q_b.size() : q_a.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_write actual=addr %0d data %h required=no write t=%0t",
                     sel ? "b" : "a", obs(sel, O_ADDR), obs(sel, O_WDATA), $time);
         end else begin
            w = sel ? q_b.pop_front() : q_a.pop_front();
            check(sel, "wr_addr", obs(sel, O_ADDR), 32'(w.addr));
            check(sel, "wr_data", obs(sel, O_WDATA), w.data);
            $display("write %s addr=%0d data=%h", sel ? "b" : "a", w.addr, w.data);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor(1'b0);
      monitor(1'b1);
   endtask

   task automatic set_in(input bit sel, input logic v, input logic [31:0] d);
      if (sel) begin
         bus_b.in_valid = v;
         bus_b.in_data  = d;
      end else begin
         bus_a.in_valid = v;
         bus_a.in_data  = d;
      end
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   task automatic check_reset(input bit sel);
      check(sel, "rst_ready",  obs(sel, O_READY),  32'd0);
      check(sel, "rst_we",     obs(sel, O_WE),     32'd0);
      check(sel, "rst_cpurst", obs(sel, O_CPURST), 32'd1);
      check(sel, "rst_done",   obs(sel, O_DONE),   32'd0);
      check(sel, "rst_err",    obs(sel, O_ERR),    32'd0);
      check(sel, "rst_count",  obs(sel, O_COUNT),  32'd0);
      check(sel, "rst_addr",   obs(sel, O_ADDR),   32'd0);
      check(sel, "rst_wdata",  obs(sel, O_WDATA),  32'd0);
   endtask

   task automatic pulse_start(input bit sel);
      set_start(sel, 1'b1);
      tick();
      set_start(sel, 1'b0);
      check(sel, "start_cpurst", obs(sel, O_CPURST), 32'd1);
      check(sel, "start_done",   obs(sel, O_DONE),   32'd0);
      check(sel, "start_ready",  obs(sel, O_READY),  32'd1);
      check(sel, "start_count",  obs(sel, O_COUNT),  32'd0);
      check(sel, "start_err",    obs(sel, O_ERR),    32'd0);
   endtask

   // One accepted word: driven this cycle, write expected exactly one cycle later.
   task automatic send_word(input bit sel, input logic [31:0] data, input int exp_addr);
      wr_t w;
      w.addr = exp_addr;
      w.data = data;
      set_in(sel, 1'b1, data);
      check(sel, "send_ready", obs(sel, O_READY), 32'd1);
      if (sel) q_b.push_back(w);
      else     q_a.push_back(w);
      tick();
      check(sel, "we_latency", obs(sel, O_WE), 32'd1);
      set_in(sel, 1'b0, 32'h0);
   endtask

   // Entered in the cycle after the marker handshake; the core is released four cycles later.
   task automatic wait_release(input bit sel, input int exp_count, input bit poke_start);
      check(sel, "rel_ready",  obs(sel, O_READY),  32'd0);
      check(sel, "rel_cpurst", obs(sel, O_CPURST), 32'd1);
      if (poke_start) set_start(sel, 1'b1);
      for (int k = 2; k <= 5; k++) begin
         tick();
         if (k == 2) set_start(sel, 1'b0);
         check(sel, "rel_cpurst_seq", obs(sel, O_CPURST), (k == 5) ? 32'd0 : 32'd1);
         check(sel, "rel_done_seq",   obs(sel, O_DONE),   (k == 5) ? 32'd1 : 32'd0);
         check(sel, "rel_ready_seq",  obs(sel, O_READY),  32'd0);
      end
      check(sel, "run_err",   obs(sel, O_ERR),   32'd0);
      check(sel, "run_count", obs(sel, O_COUNT), 32'(exp_count));
   endtask

   task automatic run_program(input int gap);
      pulse_start(1'b0);
      for (int i = 0; i < 5; i++) begin
         send_word(1'b0, prog[i].data, i);
         check(1'b0, "prog_count", obs(1'b0, O_COUNT), 32'(prog[i].exp_count));
         if (gap > 0 && i < 4) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               check(1'b0, "gap_no_we", obs(1'b0, O_WE), 32'd0);
            end
         end
      end
      wait_release(1'b0, 5, 1'b0);
   endtask

   initial begin
      prog[0] = '{32'h0000_2103, 1};
      prog[1] = '{32'h0011_0213, 2};
      prog[2] = '{32'h0021_0413, 3};
      prog[3] = '{32'h0022_04B3, 4};
      prog[4] = '{32'hFFFF_FFFF, 5};

      reset_a = 1'b1;
      reset_b = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      set_in(1'b0, 1'b0, 32'h0);
      set_in(1'b1, 1'b0, 32'h0);
      tick();
      tick();
      check_reset(1'b0);
      check_reset(1'b1);
      reset_a = 1'b0;
      reset_b = 1'b0;
      tick();
      check_reset(1'b0);
      check_reset(1'b1);

      // Basic back-to-back load, then the same program with 3-cycle gaps (a reload from RUN).
      run_program(0);
      run_program(3);

      // Reload with a short program; a start pulse during RELEASE must be ignored.
      pulse_start(1'b0);
      send_word(1'b0, 32'h0000_0013, 0);
      send_word(1'b0, 32'hFFFF_FFFF, 1);
      wait_release(1'b0, 2, 1'b1);

      // Overflow on the 4-word memory.
      pulse_start(1'b1);
      for (int i = 0; i < 4; i++) send_word(1'b1, 32'h0000_1000 + 32'(i), i);
      check(1'b1, "ovf_err",    obs(1'b1, O_ERR),    32'd1);
      check(1'b1, "ovf_count",  obs(1'b1, O_COUNT),  32'd4);
      check(1'b1, "ovf_cpurst", obs(1'b1, O_CPURST), 32'd1);
      check(1'b1, "ovf_ready",  obs(1'b1, O_READY),  32'd0);
      check(1'b1, "ovf_done",   obs(1'b1, O_DONE),   32'd0);
      set_in(1'b1, 1'b1, 32'h0000_DEAD);
      for (int i = 0; i < 3; i++) begin
         tick();
         check(1'b1, "err_no_we",   obs(1'b1, O_WE),    32'd0);
         check(1'b1, "err_ready",   obs(1'b1, O_READY), 32'd0);
         check(1'b1, "err_sticky",  obs(1'b1, O_ERR),   32'd1);
      end
      set_in(1'b1, 1'b0, 32'h0);
      pulse_start(1'b1);
      send_word(1'b1, 32'h0000_0093, 0);
      send_word(1'b1, 32'hFFFF_FFFF, 1);
      wait_release(1'b1, 2, 1'b0);

      // Marker in the last slot loads without error.
      pulse_start(1'b1);
      for (int i = 0; i < 3; i++) send_word(1'b1, 32'h0000_2000 + 32'(i), i);
      send_word(1'b1, 32'hFFFF_FFFF, 3);
      check(1'b1, "last_slot_err", obs(1'b1, O_ERR), 32'd0);
      wait_release(1'b1, 4, 1'b0);

      // Reset in the middle of a load; the word offered with reset must not be written.
      pulse_start(1'b0);
      send_word(1'b0, 32'h0000_00AA, 0);
      send_word(1'b0, 32'h0000_00BB, 1);
      set_in(1'b0, 1'b1, 32'h0000_BAD0);
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      check_reset(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check(1'b0, "idle_no_we",  obs(1'b0, O_WE),     32'd0);
         check(1'b0, "idle_ready",  obs(1'b0, O_READY),  32'd0);
         check(1'b0, "idle_cpurst", obs(1'b0, O_CPURST), 32'd1);
      end
      set_in(1'b0, 1'b0, 32'h0);
      tick();

      check(1'b0, "sb_empty", 32'(q_a.size()), 32'd0);
      check(1'b1, "sb_empty", 32'(q_b.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined RISC-V core. Accepts 32-bit instruction words over a valid/ready stream and writes them to consecutive instruction-memory word addresses. Holds the CPU in reset until the program's terminating marker word (the halt instruction, `0xFFFFFFFF`) has been written. It replaces hierarchical memory preloading with a synthesizable path, and pairs with the core's `end_program` halt detection at the other end of the program lifecycle.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- `END_MARKER`, default 32'hFFFFFFFF: terminating word. It is written to memory, then ends the load.
- `RELEASE_DELAY`, default 4: cycles spent in RELEASE before CPU reset is dropped. Must be ≥1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load session.
- `in_valid`  in  1  stream word valid.
- `in_data`  in  32  stream word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  write data.
- `cpu_reset`  out  1  reset to the core. High while not running.
- `load_done`  out  1  program loaded, core released.
- `error`  out  1  memory filled without a marker.
- `word_count`  out  ADDR_WIDTH+1  words written this session, marker included.

## Operation
- States:
  - IDLE: reset entry. `cpu_reset`=1. `start` → LOAD.
  - LOAD: `in_ready`=1. On `in_valid&in_ready` the word is written at `addr`, then `addr`+1 and `word_count`+1.
    - Accepted word == END_MARKER → RELEASE.
    - Non-marker accepted at `addr`=2^ADDR_WIDTH−1 → ERROR. The word is still written.
    - Marker at the last address → RELEASE, with no error.
  - RELEASE: `in_ready`=0, `cpu_reset`=1. The delay counter runs RELEASE_DELAY cycles, then → RUN.
  - RUN: `cpu_reset`=0, `load_done`=1. `start` → LOAD (reload).
  - ERROR: `error`=1, `cpu_reset`=1, `in_ready`=0. `start` → LOAD.
- On every LOAD entry, `addr`=0, `word_count`=0, `error`=0 and `load_done`=0 are cleared.
- `start` is ignored in LOAD and RELEASE. `in_valid` is ignored outside LOAD; no word is consumed.
- Address wrap never occurs: ERROR is entered before `addr` would wrap.
- Reset values: state IDLE, `cpu_reset`=1, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_done`=0, `error`=0, `word_count`=0.
- Synchronous reset overrides everything, including mid-load or mid-release. The partial memory contents are left as written; no further writes occur.

## Timing
- `in_ready` is a Moore output, high exactly in cycles where state==LOAD.
- Write latency is 1: handshake in cycle N → `imem_we`=1 in cycle N+1, with `imem_addr` and `imem_wdata` registered. `imem_we`=0 in all other cycles.
- Back-to-back handshakes give one write per cycle, so full throughput is 1 word/cycle.
- Marker handshake in cycle N:
  - state = RELEASE in N+1..N+RELEASE_DELAY;
  - `cpu_reset` falls and `load_done` rises in N+RELEASE_DELAY+1.
- `word_count` and `error` update in the same cycle as the corresponding `imem_we`.
- `start` sampled in RUN in cycle N: `cpu_reset`=1, `load_done`=0 and `in_ready`=1 from N+1.

## Test plan
- Basic load: `start`, then stream 0x00002103, 0x00110213, 0x00210413, 0x002204B3, 0xFFFFFFFF back-to-back.
  - Expect 5 writes to addr 0..4 with matching data.
  - `word_count`=5, `error`=0.
  - `cpu_reset` falls exactly 5 cycles after the marker handshake.
- Backpressure/gaps: same program with `in_valid` low for 3 cycles between words.
  - Identical memory image and `word_count`=5.
  - No write during the gaps.
- Overflow (ADDR_WIDTH=2): stream 4 non-marker words.
  - 4 writes, `error`=1, `word_count`=4, `cpu_reset` stays 1, `in_ready`=0.
  - Then `start` clears `error`, and a 2-word program (X, marker) loads with `word_count`=2.
- Marker at last slot (ADDR_WIDTH=2): 3 words + marker.
  - `error`=0, RUN reached, `word_count`=4.
- Reset mid-load: assert `reset` after 2 accepted words.
  - Next cycle: all outputs at reset values, state IDLE.
  - `in_valid` with no `start` produces no writes.
- Reload: in RUN pulse `start`, stream 0x00000013, marker.
  - `cpu_reset`=1 and `load_done`=0 the next cycle.
  - Writes go to addr 0..1, then release again.
  - A `start` pulse during RELEASE has no effect.
